filter_stim_ctrl: RTL
=====================

Name: filter_stim_ctrl

Overview:
- Sequences a programmed table of fixed-point input levels into the emulated filter's `v_in`.
- Holds each level for a programmed dwell, and per step measures whether and when `v_out` settles to within a tolerance of the applied level.
- Sits between the emulation control registers and the filter in the top-level testbench.
- Emits one step record per level plus a probe trigger at sequence start.

Parameters:
- WIDTH, 18, signed fixed-point width of `v_in` / `v_out` / table entries (same scaling as the filter's real ports).
- ADDR_W, 4, level-table address width; table depth 2**ADDR_W.
- DWELL_W, 16, width of dwell and settle-time counters.
- CNT_W, 8, width of the settle-count qualifier.

Ports:
- emu_clk  in  1  emulation clock
- emu_rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins sequence when idle
- abort  in  1  one-cycle pulse; stops sequence
- level_we  in  1  table write enable
- level_addr  in  ADDR_W  table write address
- level_wdata  in  WIDTH  signed level to write
- num_levels  in  ADDR_W+1  levels per sequence (0..2**ADDR_W)
- dwell  in  DWELL_W  DWELL-state cycles per level
- tol  in  WIDTH  unsigned settle tolerance
- settle_cnt  in  CNT_W  consecutive in-tolerance cycles required
- v_out  in  WIDTH  signed filter output
- v_in  out  WIDTH  signed filter input
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at sequence completion
- probe_trig  out  1  one-cycle pulse when first level is applied
- step_valid  out  1  one-cycle pulse per completed level
- step_idx  out  ADDR_W  index of the reported step
- step_settled  out  1  step met the settle criterion
- step_settle_time  out  DWELL_W  DWELL cycles from level start to settle-criterion met

Behaviour:
- Reset: all outputs 0, state IDLE, index 0, counters 0.
- Table:
  - Register array, written on `level_we` only in IDLE; writes while busy are ignored.
  - Contents are not cleared by reset.
- States: IDLE, LOAD, DWELL, NEXT, DONE.
- IDLE:
  - `start` with `num_levels` = 0 goes to DONE.
  - `start` otherwise goes to LOAD, index 0.
  - `start` while busy is ignored.
- LOAD (1 cycle):
  - `v_in` <= table[index], registered; visible the cycle after LOAD.
  - Counters are cleared.
  - `probe_trig` pulses in the cycle `v_in` first takes table[0].
  - Then go to DWELL.
- DWELL:
  - Lasts max(`dwell`, 1) cycles.
  - Each cycle: diff = `v_out` − `v_in` computed in WIDTH+1 bits, absolute value, compared unsigned against `tol` zero-extended.
  - In tolerance: run counter += 1. Otherwise: run counter cleared.
  - The first time the run count reaches `settle_cnt`, set the settled flag and latch `step_settle_time` = elapsed DWELL cycle count, where the first DWELL cycle is 1.
  - `settle_cnt` = 0: settled with time 0.
  - Counters saturate and do not wrap.
- NEXT (1 cycle):
  - `step_valid` = 1 with `step_idx`, `step_settled`, `step_settle_time`; these fields hold until the next `step_valid`.
  - If index == `num_levels` − 1, go to DONE; else index += 1 and go to LOAD.
- DONE (1 cycle): `done` = 1, go to IDLE.
- `v_in` holds the last level after DONE until the next `start` or abort.
- Per-level hold of `v_in` is `dwell` + 2 cycles (DWELL + NEXT + LOAD).
- `num_levels`, `dwell`, `tol`, `settle_cnt` are sampled live; they must be stable while busy (software rule, not checked).
- `abort` in any non-IDLE state:
  - Next state IDLE and `v_in` <= 0.
  - No `step_valid` or `done` for the interrupted step.
  - `abort` has priority over all transitions, including `start` in the same cycle.
- Async reset mid-sequence: immediate return to reset values.

Optional Feature:
- Macro: STIM_LOOP_EN.
- Defined:
  - In NEXT at the last index, go to LOAD with index 0 instead of DONE, so the sequence repeats until `abort`.
  - `probe_trig` pulses on every wrap to level 0.
  - `done` never asserts.
- Undefined: single pass as above; the wrap path is not synthesized.

Test Plan:
1. Table {0.5, −0.5, 1.0}, `num_levels`=3, `dwell`=100, `tol`=0, `v_out` tied to `v_in` → three `step_valid` pulses with idx 0,1,2, settled=1, time=`settle_cnt`; `done` at cycle 3·102+2 after `start`.
2. Filter instance in loop, `dwell`=5, `tol`=0.01 → `step_settled`=0 and time=0 on every step; `v_in` matches table values at the correct cycles.
3. `start` with `num_levels`=0 → `done` two cycles later; no `probe_trig`, no `step_valid`, `v_in` stays 0.
4. `abort` in 2nd DWELL cycle of step 1 → `busy` low next cycle, `v_in`=0, only the step-0 `step_valid` observed, no `done`; `level_we` during the run has no effect.
5. `v_out` = `v_in` + tol exactly vs `v_in` + tol + 1 LSB, `settle_cnt`=4, `dwell`=10 → settled=1 with time=4 in the first case; settled=0 in the second; `v_in` = −max-negative handled without overflow.
6. STIM_LOOP_EN defined, 2 levels, `dwell`=3 → step_idx sequence 0,1,0,1,…; `probe_trig` every 10 cycles; `done` never asserts; reset asserted mid-DWELL clears all outputs asynchronously.

Source files
------------

// File: rtl/filter_stim_ctrl.sv
// -----------------------------------------------------------------------------
// filter_stim_ctrl
//
// Purpose
//   Steps the emulated filter's input `v_in` through a programmed table of
//   signed fixed-point levels. Each level is held for a programmed dwell.
//   During the dwell the block watches `v_out` and records whether, and after
//   how many dwell cycles, the output stayed within `tol` of the applied level
//   for `settle_cnt` consecutive cycles. One step record is emitted per level,
//   and a probe trigger fires when level 0 is first driven onto `v_in`.
//
// Configuration macro
//   STIM_LOOP_EN : when defined, the sequence wraps from the last level back
//                  to level 0 and repeats until `abort`. `probe_trig` fires on
//                  every wrap and `done` never asserts. When undefined, the
//                  block runs one pass and the wrap path is not built.
//
// Ports
//   emu_clk, emu_rst_n     clock, asynchronous active-low reset
//   start, abort           one-cycle control pulses (abort wins)
//   level_we/addr/wdata    level table write port (honoured only when idle)
//   num_levels             levels per sequence, 0..2**ADDR_W
//   dwell                  DWELL cycles per level (0 behaves as 1)
//   tol                    unsigned settle tolerance
//   settle_cnt             consecutive in-tolerance cycles needed to settle
//   v_out                  signed filter output being observed
//   v_in                   signed filter input being driven (registered)
//   busy                   high whenever the FSM is not idle
//   done                   one-cycle pulse after a single pass completes
//   probe_trig             one-cycle pulse in the cycle v_in first shows level 0
//   step_valid             one-cycle pulse per completed level
//   step_idx/settled/settle_time  step record, held until the next step_valid
//   dbg_state              current FSM state, for checkers and debug
//
// Step record interface: valid-only. step_valid is a single-cycle strobe and
// there is no ready/backpressure; a consumer must capture the fields on the
// strobe, although they also remain stable until the next strobe.
// -----------------------------------------------------------------------------
module filter_stim_ctrl #(
  parameter int WIDTH   = 18,
  parameter int ADDR_W  = 4,
  parameter int DWELL_W = 16,
  parameter int CNT_W   = 8
) (
  input  logic               emu_clk,
  input  logic               emu_rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic               level_we,
  input  logic [ADDR_W-1:0]  level_addr,
  input  logic [WIDTH-1:0]   level_wdata,
  input  logic [ADDR_W:0]    num_levels,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [WIDTH-1:0]   tol,
  input  logic [CNT_W-1:0]   settle_cnt,
  input  logic [WIDTH-1:0]   v_out,
  output logic [WIDTH-1:0]   v_in,
  output logic               busy,
  output logic               done,
  output logic               probe_trig,
  output logic               step_valid,
  output logic [ADDR_W-1:0]  step_idx,
  output logic               step_settled,
  output logic [DWELL_W-1:0] step_settle_time,
  output logic [2:0]         dbg_state
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DWELL = 3'd2,
    ST_NEXT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0]   v_in_q, v_in_d;
  logic [DWELL_W-1:0] elapsed_q, elapsed_d;      // DWELL cycles completed
  logic [CNT_W-1:0]   run_q, run_d;              // consecutive in-tolerance cycles
  logic               settled_q, settled_d;
  logic [DWELL_W-1:0] settle_time_q, settle_time_d;

  logic               probe_q, probe_d;
  logic               done_q, done_d;
  logic               step_valid_q, step_valid_d;
  logic [ADDR_W-1:0]  step_idx_q, step_idx_d;
  logic               step_settled_q, step_settled_d;
  logic [DWELL_W-1:0] step_time_q, step_time_d;

  // Level table: plain register array, deliberately not reset so that a
  // programmed table survives an emulation reset.
  logic [WIDTH-1:0]   table_q [DEPTH];
  logic               tbl_we;

  // ---------------------------------------------------------------------------
  // Settle comparator
  // The difference is formed one bit wider than the operands so that the
  // extreme case (v_out = +max, v_in = -max) cannot overflow. Its magnitude
  // then fits in WIDTH+1 unsigned bits and is compared against tol
  // zero-extended to the same width.
  // ---------------------------------------------------------------------------
  logic signed [WIDTH:0] diff;
  logic        [WIDTH:0] diff_mag;
  logic                  in_tol;

  assign diff     = $signed({v_out[WIDTH-1], v_out}) - $signed({v_in_q[WIDTH-1], v_in_q});
  assign diff_mag = diff[WIDTH] ? (~$unsigned(diff) + 1'b1) : $unsigned(diff);
  assign in_tol   = (diff_mag <= {1'b0, tol});

  // Saturating increments: neither counter may wrap.
  logic [DWELL_W-1:0] elapsed_inc;
  logic [CNT_W-1:0]   run_inc;

  assign elapsed_inc = (&elapsed_q) ? elapsed_q : elapsed_q + 1'b1;
  assign run_inc     = (&run_q)     ? run_q     : run_q + 1'b1;

  // Current index is the last level of the sequence.
  logic is_last;
  assign is_last = ({1'b0, idx_q} == (num_levels - 1'b1));

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    v_in_d         = v_in_q;
    elapsed_d      = elapsed_q;
    run_d          = run_q;
    settled_d      = settled_q;
    settle_time_d  = settle_time_q;
    probe_d        = 1'b0;
    done_d         = 1'b0;
    step_valid_d   = 1'b0;
    step_idx_d     = step_idx_q;
    step_settled_d = step_settled_q;
    step_time_d    = step_time_q;
    tbl_we         = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        tbl_we = level_we;
        if (start) begin
          idx_d = '0;
          if (num_levels == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end

      ST_LOAD: begin
        v_in_d        = table_q[idx_q];
        elapsed_d     = '0;
        run_d         = '0;
        // A zero qualifier counts as settled immediately with time 0.
        settled_d     = (settle_cnt == '0);
        settle_time_d = '0;
        // Registered alongside v_in so both change in the same cycle.
        probe_d       = (idx_q == '0);
        state_d       = ST_DWELL;
      end

      ST_DWELL: begin
        elapsed_d = elapsed_inc;
        run_d     = in_tol ? run_inc : '0;
        // run_d climbs by one from zero, so equality marks the first time
        // the qualifier is met within this step.
        if (!settled_q && (run_d == settle_cnt)) begin
          settled_d     = 1'b1;
          settle_time_d = elapsed_inc;
        end
        // elapsed_inc is the 1-based number of the current DWELL cycle;
        // dwell = 0 still yields one DWELL cycle.
        if (elapsed_inc >= dwell) begin
          state_d = ST_NEXT;
        end
      end

      ST_NEXT: begin
        step_valid_d   = 1'b1;
        step_idx_d     = idx_q;
        step_settled_d = settled_q;
        step_time_d    = settle_time_q;
        if (is_last) begin
`ifdef STIM_LOOP_EN
          idx_d   = '0;
          state_d = ST_LOAD;
`else
          state_d = ST_DONE;
`endif
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_LOAD;
        end
      end

      ST_DONE: begin
`ifndef STIM_LOOP_EN
        done_d = 1'b1;
`endif
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort overrides every transition in any active state: v_in is parked at
    // zero and the interrupted step produces neither a record nor done.
    if (abort && (state_q != ST_IDLE)) begin
      state_d      = ST_IDLE;
      idx_d        = '0;
      v_in_d       = '0;
      probe_d      = 1'b0;
      done_d       = 1'b0;
      step_valid_d = 1'b0;
      step_idx_d     = step_idx_q;
      step_settled_d = step_settled_q;
      step_time_d    = step_time_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge emu_clk or negedge emu_rst_n) begin
    if (!emu_rst_n) begin
      state_q        <= ST_IDLE;
      idx_q          <= '0;
      v_in_q         <= '0;
      elapsed_q      <= '0;
      run_q          <= '0;
      settled_q      <= 1'b0;
      settle_time_q  <= '0;
      probe_q        <= 1'b0;
      done_q         <= 1'b0;
      step_valid_q   <= 1'b0;
      step_idx_q     <= '0;
      step_settled_q <= 1'b0;
      step_time_q    <= '0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      v_in_q         <= v_in_d;
      elapsed_q      <= elapsed_d;
      run_q          <= run_d;
      settled_q      <= settled_d;
      settle_time_q  <= settle_time_d;
      probe_q        <= probe_d;
      done_q         <= done_d;
      step_valid_q   <= step_valid_d;
      step_idx_q     <= step_idx_d;
      step_settled_q <= step_settled_d;
      step_time_q    <= step_time_d;
    end
  end

  always_ff @(posedge emu_clk) begin
    if (tbl_we) begin
      table_q[level_addr] <= level_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign v_in             = v_in_q;
  assign busy             = (state_q != ST_IDLE);
  assign done             = done_q;
  assign probe_trig       = probe_q;
  assign step_valid       = step_valid_q;
  assign step_idx         = step_idx_q;
  assign step_settled     = step_settled_q;
  assign step_settle_time = step_time_q;
  assign dbg_state        = state_q;

endmodule
